// File: rtl/img2col_layer_sequencer.sv
// Layer sequencer for the Img2Col datapath: walks a programmed descriptor
// table, drives one layer's geometry at a time, issues the start pulse,
// counts mLast completions, flushes the FIFO between layers and watches
// for stalled layers.
module img2col_layer_sequencer #(
  parameter int unsigned MAX_LAYERS   = 8,
  parameter int unsigned LAYER_AW     = 3,
  parameter int unsigned FLUSH_CYCLES = 4,
  parameter int unsigned TIMEOUT_W    = 20
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [LAYER_AW-1:0] cfg_layer,
  input  logic [3:0]          cfg_field,
  input  logic [15:0]         cfg_wdata,
  input  logic                go,
  input  logic [LAYER_AW:0]   num_layers,
  input  logic                abort,
  input  logic                img_mvalid,
  input  logic                img_mready,
  input  logic                img_mlast,
  output logic [191:0]        img_cfg,
  output logic                img_start,
  output logic                fifo_clear,
  output logic [LAYER_AW-1:0] cur_layer,
  output logic                busy,
  output logic                done,
  output logic                timeout_err
);

  localparam int unsigned NUM_FIELDS = 13;
  localparam int unsigned CFG_FIELDS = 12;
  localparam int unsigned FIELD_W    = 4;
  localparam int unsigned LAST_IDX   = 12;
  localparam int unsigned CNT_W      = LAYER_AW + 1;
  localparam int unsigned FLUSH_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_e;

  // Descriptor table; intentionally not reset.
  logic [15:0] desc_q [MAX_LAYERS][NUM_FIELDS];

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [LAYER_AW-1:0]  cur_layer_q, cur_layer_d;
  logic [15:0]          last_cnt_q, last_cnt_d;
  logic [15:0]          last_tgt_q, last_tgt_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic [FLUSH_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic                 timeout_err_q, timeout_err_d;
  logic [191:0]         img_cfg_q, img_cfg_d;
  logic                 img_start_q, img_start_d;
  logic                 fifo_clear_q, fifo_clear_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic beat;
  assign beat = img_mvalid & img_mready;

  // Host descriptor writes, accepted in every state; fields 13..15 dropped.
  always_ff @(posedge clk) begin
    if (cfg_we && (cfg_field < FIELD_W'(NUM_FIELDS))) begin
      desc_q[cfg_layer][cfg_field] <= cfg_wdata;
    end
  end

  // Next-state logic and registered-output next values.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    cur_layer_d   = cur_layer_q;
    last_cnt_d    = last_cnt_q;
    last_tgt_d    = last_tgt_q;
    wd_d          = wd_q;
    flush_cnt_d   = flush_cnt_q;
    timeout_err_d = timeout_err_q;
    img_cfg_d     = img_cfg_q;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (go) begin
            if (num_layers == '0) begin
              count_d = CNT_W'(1);
            end else if (num_layers > CNT_W'(MAX_LAYERS)) begin
              count_d = CNT_W'(MAX_LAYERS);
            end else begin
              count_d = num_layers;
            end
            cur_layer_d   = '0;
            timeout_err_d = 1'b0;
            state_d       = S_LOAD;
          end
        end

        S_LOAD: begin
          for (int unsigned i = 0; i < CFG_FIELDS; i++) begin
            img_cfg_d[16*i +: 16] = desc_q[cur_layer_q][FIELD_W'(i)];
          end
          if (desc_q[cur_layer_q][LAST_IDX] == 16'd0) begin
            last_tgt_d = 16'd1;
          end else begin
            last_tgt_d = desc_q[cur_layer_q][LAST_IDX];
          end
          state_d = S_START;
        end

        S_START: begin
          last_cnt_d = '0;
          wd_d       = '0;
          state_d    = S_RUN;
        end

        S_RUN: begin
          if (img_mlast) begin
            wd_d = '0;
            if ((last_cnt_q + 16'd1) == last_tgt_q) begin
              flush_cnt_d = '0;
              state_d     = S_FLUSH;
            end else begin
              last_cnt_d = last_cnt_q + 16'd1;
            end
          end else if (beat) begin
            wd_d = '0;
          end else if (wd_q == (WD_MAX - TIMEOUT_W'(1))) begin
            wd_d          = WD_MAX;
            timeout_err_d = 1'b1;
            flush_cnt_d   = '0;
            state_d       = S_FLUSH;
          end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + TIMEOUT_W'(1);
          end
        end

        S_FLUSH: begin
          if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) begin
            if (!timeout_err_q && ((CNT_W'(cur_layer_q) + CNT_W'(1)) < count_q)) begin
              cur_layer_d = cur_layer_q + LAYER_AW'(1);
              state_d     = S_LOAD;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    img_start_d  = (state_d == S_START);
    fifo_clear_d = (state_d == S_IDLE) || (state_d == S_FLUSH) || (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d       = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= CNT_W'(1);
      cur_layer_q   <= '0;
      last_cnt_q    <= '0;
      last_tgt_q    <= 16'd1;
      wd_q          <= '0;
      flush_cnt_q   <= '0;
      timeout_err_q <= 1'b0;
      img_cfg_q     <= '0;
      img_start_q   <= 1'b0;
      fifo_clear_q  <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      cur_layer_q   <= cur_layer_d;
      last_cnt_q    <= last_cnt_d;
      last_tgt_q    <= last_tgt_d;
      wd_q          <= wd_d;
      flush_cnt_q   <= flush_cnt_d;
      timeout_err_q <= timeout_err_d;
      img_cfg_q     <= img_cfg_d;
      img_start_q   <= img_start_d;
      fifo_clear_q  <= fifo_clear_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign img_cfg     = img_cfg_q;
  assign img_start   = img_start_q;
  assign fifo_clear  = fifo_clear_q;
  assign cur_layer   = cur_layer_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule
